// File: rtl/wgt_stream_server.sv
// rtl/wgt_stream_server.sv - loadable weight/feature buffer answering a one-cycle read-request handshake
// Each served request returns TILING packed words one cycle later; unserved cycles drive zero.
module wgt_stream_server #(
    parameter int WEIGHT_WIDTH = 13,
    parameter int DEPTH        = 1024,
    parameter int TILING       = 1,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int LEN_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                             clk1,
    input  logic                             rst,
    input  logic                             ld_en,
    input  logic [ADDR_WIDTH-1:0]            ld_addr,
    input  logic [WEIGHT_WIDTH-1:0]          ld_data,
    input  logic                             start,
    input  logic [LEN_WIDTH-1:0]             cfg_len,
    input  logic                             rd_req,
    output logic [TILING*WEIGHT_WIDTH-1:0]   data_out,
    output logic                             data_valid,
    output logic                             done,
    output logic                             busy,
    output logic                             underrun
);

    // One spare bit so ptr+TILING never wraps before the last-tile compare.
    localparam int PW = LEN_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] TILE_P  = PW'(TILING);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t                          state_q, state_d;
    logic [PW-1:0]                   ptr_q, ptr_d;
    logic [PW-1:0]                   len_q, len_d;
    logic                            underrun_d;
    logic                            valid_d, done_d, serve;
    logic [PW-1:0]                   cfg_len_c, base, lim, addr;
    logic [TILING*WEIGHT_WIDTH-1:0]  data_d;
    logic [WEIGHT_WIDTH-1:0]         mem [DEPTH];

    always_ff @(posedge clk1) begin
        if (ld_en && ({{(PW-ADDR_WIDTH){1'b0}}, ld_addr} < DEPTH_P)) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        cfg_len_c  = ({1'b0, cfg_len} > DEPTH_P) ? DEPTH_P : {1'b0, cfg_len};
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        underrun_d = underrun;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        serve      = 1'b0;
        base       = ptr_q;
        lim        = len_q;
        addr       = '0;
        data_d     = '0;

        // A start in the same cycle as rd_req serves that request as tile 0 of the new stream.
        if (start) begin
            len_d      = cfg_len_c;
            ptr_d      = '0;
            underrun_d = 1'b0;
            base       = '0;
            lim        = cfg_len_c;
            if (cfg_len_c == '0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = S_ACTIVE;
                serve   = rd_req;
            end
        end else if (state_q == S_ACTIVE) begin
            serve = rd_req;
        end else if (rd_req) begin
            underrun_d = 1'b1;
        end

        if (serve) begin
            valid_d = 1'b1;
            for (int k = 0; k < TILING; k++) begin
                addr = base + PW'(k);
                if (addr < lim) begin
                    data_d[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = mem[addr[ADDR_WIDTH-1:0]];
                end
            end
            if (base + TILE_P >= lim) begin
                done_d  = 1'b1;
                ptr_d   = '0;
                state_d = S_IDLE;
            end else begin
                ptr_d = base + TILE_P;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            len_q      <= '0;
            underrun   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            underrun   <= underrun_d;
            data_out   <= data_d;
            data_valid <= valid_d;
            done       <= done_d;
        end
    end

    assign busy = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_wgt_stream_server.sv
// tb/tb_wgt_stream_server.sv - self-checking bench for wgt_stream_server (TILING=1 and TILING=8 instances)
module tb_wgt_stream_server;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [12:0] ld_data;
    logic        start;
    logic [10:0] cfg_len;
    logic        rd_req;
    logic [12:0] d_out;
    logic        d_valid, d_done, d_busy, d_under;

    logic        e_ld_en;
    logic [4:0]  e_ld_addr;
    logic [12:0] e_ld_data;
    logic        e_start;
    logic [4:0]  e_cfg_len;
    logic        e_rd_req;
    logic [103:0] e_out;
    logic        e_valid, e_done, e_busy, e_under;

    wgt_stream_server #(.WEIGHT_WIDTH(13), .DEPTH(1024), .TILING(1)) u_t1 (
        .clk1(clk1), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .cfg_len(cfg_len), .rd_req(rd_req), .data_out(d_out),
        .data_valid(d_valid), .done(d_done), .busy(d_busy), .underrun(d_under)
    );

    wgt_stream_server #(.WEIGHT_WIDTH(13), .DEPTH(24), .TILING(8)) u_t8 (
        .clk1(clk1), .rst(rst), .ld_en(e_ld_en), .ld_addr(e_ld_addr), .ld_data(e_ld_data),
        .start(e_start), .cfg_len(e_cfg_len), .rd_req(e_rd_req), .data_out(e_out),
        .data_valid(e_valid), .done(e_done), .busy(e_busy), .underrun(e_under)
    );

    int checks = 0;
    int errors = 0;
    bit sb_on = 1'b0;

    typedef struct {
        logic [12:0] data;
        logic        done;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        start;
        logic [10:0] len;
        logic        rd;
        logic        valid;
        logic [12:0] data;
        logic        done;
        logic        under;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
        if (sb_on) begin
            if (d_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got tile %0h expected no tile", d_out);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_data", d_out, e.data);
                    chk("sb_done", d_done, e.done);
                end
            end else begin
                chk("idle_data_zero", d_out, 0);
            end
        end
    endtask

    task automatic req(input logic [12:0] data, input logic last);
        rd_req = 1'b1;
        sbq.push_back('{data, last});
        tick();
        rd_req = 1'b0;
    endtask

    task automatic load1(input int n, input int off);
        for (int i = 0; i < n; i++) begin
            ld_en   = 1'b1;
            ld_addr = 10'(i);
            ld_data = 13'(off + i);
            tick();
        end
        ld_en = 1'b0;
    endtask

    task automatic start1(input int len);
        start   = 1'b1;
        cfg_len = 11'(len);
        tick();
        start   = 1'b0;
    endtask

    function automatic logic [103:0] tile(input int base, input int len);
        logic [103:0] t;
        t = '0;
        for (int k = 0; k < 8; k++) begin
            if (base + k < len) t[k*13 +: 13] = 13'(base + k);
        end
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; cfg_len = '0; rd_req = 1'b0;
        e_ld_en = 1'b0; e_ld_addr = '0; e_ld_data = '0; e_start = 1'b0; e_cfg_len = '0; e_rd_req = 1'b0;
        tick();
        tick();
        chk("rst_valid", d_valid, 0);
        chk("rst_done", d_done, 0);
        chk("rst_busy", d_busy, 0);
        chk("rst_under", d_under, 0);
        chk("rst_data", d_out, 0);
        chk("rst_t8_data", e_out, 0);
        rst = 1'b0;

        // Test 1: TILING=1 back-to-back stream of buf[i]=i
        sb_on = 1'b1;
        load1(10, 0);
        start1(10);
        chk("t1_busy_active", d_busy, 1);
        for (int i = 0; i < 10; i++) req(13'(i), i == 9);
        chk("t1_busy_after", d_busy, 0);
        chk("t1_sb_drained", sbq.size(), 0);

        // Test 3: gapped requests then underrun, table-driven
        sb_on = 1'b0;
        tv[0] = '{1'b1, 11'd3, 1'b0, 1'b0, 13'd0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 11'd0, 1'b1, 1'b1, 13'd0, 1'b0, 1'b0};
        tv[2] = '{1'b0, 11'd0, 1'b0, 1'b0, 13'd0, 1'b0, 1'b0};
        tv[3] = '{1'b0, 11'd0, 1'b0, 1'b0, 13'd0, 1'b0, 1'b0};
        tv[4] = '{1'b0, 11'd0, 1'b1, 1'b1, 13'd1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 11'd0, 1'b1, 1'b1, 13'd2, 1'b1, 1'b0};
        tv[6] = '{1'b0, 11'd0, 1'b1, 1'b0, 13'd0, 1'b0, 1'b1};
        tv[7] = '{1'b0, 11'd0, 1'b0, 1'b0, 13'd0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            start   = tv[i].start;
            cfg_len = tv[i].len;
            rd_req  = tv[i].rd;
            tick();
            chk($sformatf("tv%0d_valid", i), d_valid, tv[i].valid);
            chk($sformatf("tv%0d_data", i), d_out, tv[i].data);
            chk($sformatf("tv%0d_done", i), d_done, tv[i].done);
            chk($sformatf("tv%0d_under", i), d_under, tv[i].under);
        end
        start = 1'b0;
        rd_req = 1'b0;

        // Test 4: restart coincident with the third request
        sb_on = 1'b1;
        load1(10, 'h100);
        start1(10);
        chk("t4_under_cleared", d_under, 0);
        req(13'h100, 1'b0);
        req(13'h101, 1'b0);
        start = 1'b1; cfg_len = 11'd10;
        req(13'h100, 1'b0);
        start = 1'b0;
        for (int i = 1; i < 10; i++) req(13'(13'h100 + i), i == 9);

        // Test 5: reset mid-stream, then a fresh short stream
        start1(10);
        req(13'h100, 1'b0);
        req(13'h101, 1'b0);
        rst = 1'b1; rd_req = 1'b1;
        tick();
        rst = 1'b0; rd_req = 1'b0;
        chk("t5_valid", d_valid, 0);
        chk("t5_done", d_done, 0);
        chk("t5_busy", d_busy, 0);
        chk("t5_under", d_under, 0);
        chk("t5_data", d_out, 0);
        start1(4);
        for (int i = 0; i < 4; i++) req(13'(13'h100 + i), i == 3);

        // Test 6: read/write collision returns old data, then zero-length start
        start1(10);
        for (int i = 0; i < 5; i++) req(13'(13'h100 + i), 1'b0);
        ld_en = 1'b1; ld_addr = 10'd5; ld_data = 13'h1ABC;
        req(13'h105, 1'b0);
        ld_en = 1'b0;
        for (int i = 6; i < 10; i++) req(13'(13'h100 + i), i == 9);
        start1(10);
        for (int i = 0; i < 10; i++) req((i == 5) ? 13'h1ABC : 13'(13'h100 + i), i == 9);
        sb_on = 1'b0;
        start1(0);
        chk("t6_len0_done", d_done, 1);
        chk("t6_len0_valid", d_valid, 0);
        chk("t6_len0_busy", d_busy, 0);
        tick();
        chk("t6_len0_done_pulse", d_done, 0);
        chk("sb_empty", sbq.size(), 0);

        // Test 2: TILING=8 with a partial last tile, then clamped length
        for (int i = 0; i < 24; i++) begin
            e_ld_en = 1'b1; e_ld_addr = 5'(i); e_ld_data = 13'(i);
            tick();
        end
        e_ld_en = 1'b0;
        e_start = 1'b1; e_cfg_len = 5'd20;
        tick();
        e_start = 1'b0;
        e_rd_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("t8_tile%0d", j), e_out, tile(j * 8, 20));
            chk($sformatf("t8_valid%0d", j), e_valid, 1);
            chk($sformatf("t8_done%0d", j), e_done, j == 2);
        end
        e_rd_req = 1'b0;
        tick();
        chk("t8_idle_valid", e_valid, 0);
        chk("t8_idle_data", e_out, 0);
        chk("t8_idle_busy", e_busy, 0);
        e_start = 1'b1; e_cfg_len = 5'd31;
        tick();
        e_start = 1'b0;
        e_rd_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("t8c_tile%0d", j), e_out, tile(j * 8, 24));
            chk($sformatf("t8c_done%0d", j), e_done, j == 2);
        end
        e_rd_req = 1'b0;
        chk("t8c_busy", e_busy, 0);
        chk("t8c_under", e_under, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
